vga_timing_gen: RTL
===================

# vga_timing_gen

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock: a pixel-rate strobe, horizontal/vertical counters, sync pulses, and the `xOrd`/`yOrd`/`visible` pixel coordinates consumed by the pixel renderers (raycaster and friends). It is the producing end of the coordinate interface. It sits between the board clock/reset and the renderer. It also supplies `hsync`/`vsync` to the DAC/connector.

## Interface
- `CLK_DIV`, 2: clocks per pixel; legal range 1..8. 50 MHz / 2 gives 25 MHz.
- `H_VISIBLE`, 640 / `H_FRONT`, 16 / `H_SYNC`, 96 / `H_BACK`, 48: horizontal segment lengths in pixels. H_TOTAL = 800.
- `V_VISIBLE`, 480 / `V_FRONT`, 10 / `V_SYNC`, 2 / `V_BACK`, 33: vertical segment lengths in lines. V_TOTAL = 525.
- `SYNC_POL`, 0: active level of `hsync`/`vsync` (0 = active-low).

Ports:
- `clock` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pixel_en` out 1: high for one clock per pixel period.
- `xOrd` out 10: horizontal count, 0..H_TOTAL-1.
- `yOrd` out 10: vertical count, 0..V_TOTAL-1.
- `visible` out 1: high when xOrd < H_VISIBLE and yOrd < V_VISIBLE.
- `hsync` out 1: horizontal sync, level per SYNC_POL.
- `vsync` out 1: vertical sync, level per SYNC_POL.
- `line_start` out 1: high when pixel_en is high and xOrd == 0.
- `frame_start` out 1: high when pixel_en is high and xOrd == 0 and yOrd == 0.
- `frame_count` out 16: number of completed frames since reset, wraps.

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps. `pixel_en` = (div == CLK_DIV-1). With CLK_DIV = 1, `pixel_en` is constantly high.
- Horizontal counter: on a clock edge with `pixel_en` high, xOrd increments. At H_TOTAL-1 it wraps to 0.
- Vertical counter: yOrd increments on the same edge as the xOrd wrap. At V_TOTAL-1 it wraps to 0.
- Frame counter: `frame_count` increments by 1 on the edge where both counters wrap (xOrd = 799 and yOrd = 524). It wraps 65535 -> 0.
- `xOrd` and `yOrd` are registers. `visible`, `line_start` and `frame_start` are decoded combinationally from the registered counters and `div`, so they have zero latency relative to the coordinates.
- hsync window: asserted (= SYNC_POL) while H_VISIBLE+H_FRONT ≤ xOrd < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751. Deasserted (= ~SYNC_POL) otherwise.
- vsync window: asserted while V_VISIBLE+V_FRONT ≤ yOrd < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491. vsync is independent of xOrd.
- State after reset: div = 0, xOrd = 0, yOrd = 0, frame_count = 0.
- Output values after reset: `visible` = 1, `pixel_en` = 0 (unless CLK_DIV = 1), `hsync`/`vsync` = ~SYNC_POL.
- `line_start` and `frame_start` are 0 after reset until the first `pixel_en`, which occurs CLK_DIV-1 clocks after reset deasserts.
- Reset mid-frame: on the next clock all state returns to its reset values. No partial line or frame completes, and `frame_count` is not incremented.
- `reset` has priority over every counter update in the same cycle.

## Timing
- Each coordinate value is held for exactly CLK_DIV clocks.
- A line lasts H_TOTAL·CLK_DIV clocks (1600). A frame lasts 525 lines (840,000 clocks, about 59.5 Hz).
- hsync active width: 96 pixels (192 clocks). vsync active width: 2 lines (3200 clocks).
- `line_start` and `frame_start` are single-clock pulses. They occur in the last clock of pixel 0, coincident with `pixel_en`.
- The renderer registers RGB one clock after sampling the coordinates. Sync alignment to that RGB is handled by the configuration option below.

## Configuration
- Macro: `VGA_SYNC_ALIGN_EN`.
- Defined: `hsync` and `vsync` each pass through one extra register, delaying them by exactly one clock relative to `xOrd`/`yOrd`. This matches the renderer's one-clock RGB register. The delay registers reset to ~SYNC_POL.
- Undefined: `hsync`/`vsync` are decoded from the current counters with zero delay.
- `visible`, the start pulses, and the counters are identical in both builds.

## Test plan
- Reset then free-run, CLK_DIV = 2: `pixel_en` is high on clocks 1, 3, 5 after reset. `xOrd` reads 0, 0, 1, 1, 2. `yOrd` = 0 and `visible` = 1.
- Line wrap: at xOrd = 799, yOrd = 10, the `pixel_en` edge gives xOrd = 0, yOrd = 11. `line_start` pulses one clock at the end of the first pixel; `frame_start` stays 0.
- hsync/visible window, macro undefined: `hsync` = 0 for exactly xOrd 656..751 (192 clocks). `visible` = 0 for xOrd 640..799 and for every yOrd ≥ 480.
- Frame wrap: xOrd = 799, yOrd = 524 -> 0, 0 and `frame_count` goes 0 -> 1. `frame_start` is high for one clock. Over the frame, `vsync` = 0 for exactly yOrd 490..491 (3200 clocks).
- Reset mid-frame: assert `reset` for one clock at xOrd = 300, yOrd = 200, frame_count = 5. Next clock: xOrd = 0, yOrd = 0, frame_count = 0, hsync = vsync = 1.
- `VGA_SYNC_ALIGN_EN` defined: `hsync` falls one clock after xOrd becomes 656 and rises one clock after xOrd becomes 752. vsync is delayed by one clock in the same way.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster coordinate/sync bundle driven by vga_timing_gen and consumed by the pixel renderers.
interface vga_timing_gen_if;
  logic        pixel_en;
  logic [9:0]  xOrd;
  logic [9:0]  yOrd;
  logic        visible;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output pixel_en, xOrd, yOrd, visible, hsync, vsync, line_start, frame_start, frame_count
  );

  modport slave (
    input pixel_en, xOrd, yOrd, visible, hsync, vsync, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator: pixel strobe, counters, syncs, frame count.
// Optional macro VGA_SYNC_ALIGN_EN delays hsync/vsync one clock to match the renderer RGB register.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      XLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0]      YLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0]      XVisEnd  = 10'(H_VISIBLE);
  localparam logic [9:0]      YVisEnd  = 10'(V_VISIBLE);
  localparam logic [9:0]      HsStart  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]      HsEnd    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]      VsStart  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]      VsEnd    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DivW-1:0] divQ, divD;
  logic [9:0]      xOrdQ, xOrdD;
  logic [9:0]      yOrdQ, yOrdD;
  logic [15:0]     frameCountQ, frameCountD;
  logic            pixelEn;
  logic            hsyncRaw, vsyncRaw;

  assign pixelEn = (divQ == DivLast);

  always_comb begin
    divD        = (divQ == DivLast) ? '0 : divQ + 1'b1;
    xOrdD       = xOrdQ;
    yOrdD       = yOrdQ;
    frameCountD = frameCountQ;
    if (pixelEn) begin
      if (xOrdQ == XLast) begin
        xOrdD = '0;
        if (yOrdQ == YLast) begin
          yOrdD       = '0;
          frameCountD = frameCountQ + 16'd1;
        end else begin
          yOrdD = yOrdQ + 10'd1;
        end
      end else begin
        xOrdD = xOrdQ + 10'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      divQ        <= '0;
      xOrdQ       <= '0;
      yOrdQ       <= '0;
      frameCountQ <= '0;
    end else begin
      divQ        <= divD;
      xOrdQ       <= xOrdD;
      yOrdQ       <= yOrdD;
      frameCountQ <= frameCountD;
    end
  end

  always_comb begin
    hsyncRaw = (xOrdQ >= HsStart && xOrdQ < HsEnd) ? SYNC_POL : ~SYNC_POL;
    vsyncRaw = (yOrdQ >= VsStart && yOrdQ < VsEnd) ? SYNC_POL : ~SYNC_POL;
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic hsyncQ, vsyncQ;

  always_ff @(posedge clock) begin
    if (reset) begin
      hsyncQ <= ~SYNC_POL;
      vsyncQ <= ~SYNC_POL;
    end else begin
      hsyncQ <= hsyncRaw;
      vsyncQ <= vsyncRaw;
    end
  end

  assign vga.hsync = hsyncQ;
  assign vga.vsync = vsyncQ;
`else
  assign vga.hsync = hsyncRaw;
  assign vga.vsync = vsyncRaw;
`endif

  assign vga.pixel_en    = pixelEn;
  assign vga.xOrd        = xOrdQ;
  assign vga.yOrd        = yOrdQ;
  assign vga.frame_count = frameCountQ;
  assign vga.visible     = (xOrdQ < XVisEnd) && (yOrdQ < YVisEnd);
  assign vga.line_start  = pixelEn && (xOrdQ == '0);
  assign vga.frame_start = pixelEn && (xOrdQ == '0) && (yOrdQ == '0);

endmodule
